dmem_loader: RTL and testbench
==============================

Name: dmem_loader

Overview:
- Initiator for the CPU top's external data-memory write port (Ext_MemWrite / Ext_WriteData / Ext_DataAdr).
- Takes a byte stream over a valid/ready handshake and packs it into 32-bit little-endian words.
- Writes each word to consecutive word addresses while holding the CPU in reset, then releases the CPU.
- Sits between a host link (e.g. a UART receiver) and the CPU top.

Parameters:
- CNT_W, 16, width of the word-count input.
- RELEASE_CYCLES, 2, cycles the CPU reset stays high after the last write before release (minimum 1).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a load; sampled only in IDLE
- base_addr  input  32  first byte address; bits [1:0] ignored (forced 0); captured on start
- word_count  input  CNT_W  number of words to load; captured on start
- in_byte  input  8  stream data byte
- in_valid  input  1  in_byte valid
- in_ready  output  1  loader accepts a byte this cycle
- Ext_MemWrite  output  1  data-memory write strobe toward the CPU top
- Ext_WriteData  output  32  word to write
- Ext_DataAdr  output  32  word-aligned write address
- cpu_reset  output  1  active-high reset driven to the CPU top; gates the Ext port
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse when cpu_reset deasserts

Behaviour:
- Reset (reset_n low, async):
  - State IDLE; cpu_reset=1 (CPU held after power-up).
  - Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=0.
  - in_ready=0, busy=0, done=0.
  - Byte counter, word counter and address register all cleared.
- All outputs are registered except in_ready, which is a decode of the state.
- IDLE:
  - On start: capture {base_addr[31:2],2'b00} and word_count; drive cpu_reset=1.
  - Go to COLLECT if word_count != 0; otherwise go to RELEASE.
  - A start pulse outside IDLE is ignored.
- COLLECT:
  - in_ready=1.
  - Each cycle with in_valid && in_ready, the byte is stored in lane k (k = 0..3, lane 0 = bits [7:0]) and k increments.
  - When the 4th byte is accepted, move to WRITE on the next edge.
  - in_valid low stalls indefinitely with no timeout; partial lanes are retained.
- WRITE (exactly 1 cycle):
  - Ext_MemWrite=1, Ext_DataAdr=current address, Ext_WriteData=assembled word; in_ready=0.
  - On exit: address += 4 (mod 2^32, wraps 0xFFFFFFFC -> 0x00000000); remaining word count -= 1.
  - Go to COLLECT if remaining words != 0, else RELEASE.
  - The Ext outputs hold their last values after the write; only Ext_MemWrite drops to 0.
- RELEASE:
  - cpu_reset stays 1 and Ext_MemWrite=0 for RELEASE_CYCLES cycles.
  - Then go to DONE.
- DONE (1 cycle):
  - cpu_reset=0, done=1; then IDLE.
  - In IDLE after a load, cpu_reset stays 0 until the next start.
- Per-word latency: the write strobe is asserted on the cycle after the 4th byte handshake.
- Minimum load time: 5 cycles per word when the stream is gap-free.
- Invariant: Ext_MemWrite=1 implies cpu_reset=1 in the same cycle. The CPU top only honours the Ext port while its reset is high.
- reset_n asserted mid-load:
  - Immediate return to the reset state.
  - No partial word is written; the next load starts from lane 0.
- Bytes presented while in_ready=0 are neither consumed nor lost. The source must hold them.

Decomposition:
- Shared package `dmem_loader_pkg`:
  - state enum (IDLE, COLLECT, WRITE, RELEASE, DONE);
  - WORD_BYTES=4;
  - ADDR_STRIDE=4.
- One sub-module, `byte_packer`: the 2-bit lane counter plus four byte registers, a clear input and a full flag. The loader FSM instantiates it.

Test Plan:
1. Reset, then start with base_addr=0x00000010, word_count=2, bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE gap-free -> writes 0x12345678@0x10 and 0xDEADBEEF@0x14, one cycle each. cpu_reset falls RELEASE_CYCLES+1 cycles after the second write, coincident with done.
2. Same load with in_valid toggling every other cycle and a 20-cycle gap after byte 2 -> identical write data and addresses; in_ready=0 only during WRITE/RELEASE/DONE.
3. base_addr=0x00000013, word_count=1, bytes 01,02,03,04 -> Ext_DataAdr=0x00000010, Ext_WriteData=0x04030201.
4. base_addr=0xFFFFFFFC, word_count=2 -> writes at 0xFFFFFFFC then 0x00000000.
5. word_count=0 -> no Ext_MemWrite pulse; done pulses RELEASE_CYCLES+1 cycles after start.
6. reset_n low after 3 bytes of word 1 -> outputs return to reset values asynchronously with no write. A second start pulse during busy in another run is ignored.

Source files
------------

// File: rtl/dmem_loader_pkg.sv
// Shared types and constants for the data-memory loader: FSM states,
// word geometry and the byte-address alignment helper.
package dmem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int          WORD_BYTES  = 4;
    localparam logic [31:0] ADDR_STRIDE = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_loader_if.sv
// Host-side control, byte stream and CPU external write port of the loader.
interface dmem_loader_if #(parameter int CNT_W = 16);

    logic             start;
    logic [31:0]      base_addr;
    logic [CNT_W-1:0] word_count;
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    logic             Ext_MemWrite;
    logic [31:0]      Ext_WriteData;
    logic [31:0]      Ext_DataAdr;
    logic             cpu_reset;
    logic             busy;
    logic             done;

    modport master (
        input  start, base_addr, word_count, in_byte, in_valid,
        output in_ready, Ext_MemWrite, Ext_WriteData, Ext_DataAdr,
               cpu_reset, busy, done
    );

    modport slave (
        output start, base_addr, word_count, in_byte, in_valid,
        input  in_ready, Ext_MemWrite, Ext_WriteData, Ext_DataAdr,
               cpu_reset, busy, done
    );

endinterface

// File: rtl/dmem_loader_byte_packer.sv
// Little-endian byte-to-word packer: a 2-bit lane pointer and four byte lanes.
// word_s already merges the incoming byte so the word is usable on the 4th push.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_s,
    input  logic        push_s,
    input  logic [7:0]  data_s,
    output logic        full_s,
    output logic [31:0] word_s
);

    logic [1:0]       lane_r;
    logic [3:0][7:0]  bytes_r;

    // lane pointer and byte storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_r  <= 2'd0;
            bytes_r <= 32'd0;
        end else if (clear_s) begin
            lane_r  <= 2'd0;
            bytes_r <= 32'd0;
        end else if (push_s) begin
            bytes_r[lane_r] <= data_s;
            lane_r          <= lane_r + 2'd1;
        end else begin
            lane_r  <= lane_r;
            bytes_r <= bytes_r;
        end
    end

    assign full_s = push_s && (lane_r == 2'd3);
    assign word_s = full_s ? {data_s, bytes_r[2], bytes_r[1], bytes_r[0]} : bytes_r;

endmodule

// File: rtl/dmem_loader.sv
// Streams bytes into 32-bit words and writes them through the CPU external
// memory port while holding the CPU in reset, then releases it.
module dmem_loader
    import dmem_loader_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    dmem_loader_if.master bus
);

    localparam int               RC_W     = $clog2(RELEASE_CYCLES + 1) + 1;
    localparam logic [RC_W-1:0]  REL_LAST = RC_W'(RELEASE_CYCLES - 1);
    localparam logic [RC_W-1:0]  REL_ONE  = {{(RC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [CNT_W-1:0] remaining_r;
    logic [31:0]      addr_r;
    logic [RC_W-1:0]  rel_cnt_r;
    logic             clear_s, push_s, full_s, start_ok_s;
    logic [31:0]      word_s;

    logic             mem_write_r, cpu_reset_r, busy_r, done_r;
    logic [31:0]      write_data_r, data_adr_r;

    byte_packer u_packer (
        .clk     (clk),
        .rst_n   (reset_n),
        .clear_s (clear_s),
        .push_s  (push_s),
        .data_s  (bus.in_byte),
        .full_s  (full_s),
        .word_s  (word_s)
    );

    assign start_ok_s   = (state_r == IDLE) && bus.start;
    assign bus.in_ready = (state_r == COLLECT);

    // next-state decode and packer control
    always_comb begin
        state_s = state_r;
        clear_s = 1'b0;
        push_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    clear_s = 1'b1;
                    state_s = (bus.word_count != CNT_ZERO) ? COLLECT : RELEASE;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                push_s  = bus.in_valid;
                state_s = full_s ? WRITE : COLLECT;
            end
            WRITE: begin
                state_s = (remaining_r == CNT_ONE) ? RELEASE : COLLECT;
            end
            RELEASE: begin
                state_s = (rel_cnt_r == REL_LAST) ? DONE : RELEASE;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // load address, remaining word count and release delay counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r      <= 32'd0;
            remaining_r <= CNT_ZERO;
            rel_cnt_r   <= {RC_W{1'b0}};
        end else begin
            if (start_ok_s) begin
                addr_r      <= align_word(bus.base_addr);
                remaining_r <= bus.word_count;
            end else if (state_r == WRITE) begin
                addr_r      <= addr_r + ADDR_STRIDE;
                remaining_r <= remaining_r - CNT_ONE;
            end else begin
                addr_r      <= addr_r;
                remaining_r <= remaining_r;
            end
            rel_cnt_r <= (state_r == RELEASE) ? rel_cnt_r + REL_ONE : {RC_W{1'b0}};
        end
    end

    // registered outputs, decoded from the upcoming state so they align with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_write_r  <= 1'b0;
            write_data_r <= 32'd0;
            data_adr_r   <= 32'd0;
            cpu_reset_r  <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            mem_write_r <= (state_s == WRITE);
            if ((state_r == COLLECT) && (state_s == WRITE)) begin
                write_data_r <= word_s;
                data_adr_r   <= addr_r;
            end else begin
                write_data_r <= write_data_r;
                data_adr_r   <= data_adr_r;
            end
            if (state_s == DONE) begin
                cpu_reset_r <= 1'b0;
            end else if (start_ok_s) begin
                cpu_reset_r <= 1'b1;
            end else begin
                cpu_reset_r <= cpu_reset_r;
            end
            busy_r <= (state_s != IDLE);
            done_r <= (state_s == DONE);
        end
    end

    assign bus.Ext_MemWrite  = mem_write_r;
    assign bus.Ext_WriteData = write_data_r;
    assign bus.Ext_DataAdr   = data_adr_r;
    assign bus.cpu_reset     = cpu_reset_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;

endmodule

// File: tb/tb_dmem_loader.sv
// Scoreboard bench for dmem_loader: loads queue expected writes, a negedge
// monitor checks every write strobe and done pulse against them.
module tb_dmem_loader;

    localparam int RC = 2;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   vectors;
    int   miscompares;

    wr_t        sb[$];
    logic [7:0] tx_bytes[$];
    int         exp_words;
    int         exp_start_cyc;
    int         last_wr_cyc;

    dmem_loader_if #(.CNT_W(16)) bus();

    dmem_loader #(.CNT_W(16), .RELEASE_CYCLES(RC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: write strobes, done pulse and idle handshake invariant
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.Ext_MemWrite === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got write %h@%h, expected none",
                             bus.Ext_WriteData, bus.Ext_DataAdr);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("write_addr", bus.Ext_DataAdr, e.a);
                    chk("write_data", bus.Ext_WriteData, e.d);
                end
                chk("write_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
                chk("write_in_ready", {31'd0, bus.in_ready}, 32'd0);
                last_wr_cyc = cyc;
            end
            if (bus.done === 1'b1) begin
                chk("done_cycle", cyc,
                    (exp_words == 0) ? exp_start_cyc + RC + 1 : last_wr_cyc + RC + 1);
                chk("done_cpu_reset", {31'd0, bus.cpu_reset}, 32'd0);
                chk("done_pending_writes", sb.size(), 32'd0);
            end
            if (bus.busy === 1'b0 && bus.in_ready !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL idle_in_ready: got %b, expected 0", bus.in_ready);
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        chk("rst_memwrite", {31'd0, bus.Ext_MemWrite}, 32'd0);
        chk("rst_wdata", bus.Ext_WriteData, 32'd0);
        chk("rst_addr", bus.Ext_DataAdr, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
    endtask

    task automatic pulse_start(input logic [31:0] base, input int wc);
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = 16'(wc);
        exp_start_cyc  = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // mode 0: gap-free, 1: alternate idle cycles with a long gap and a stray start, 2: random gaps
    task automatic send_bytes(input int mode);
        for (int i = 0; i < tx_bytes.size(); i++) begin
            int  idle;
            int  t;
            bit  ok;
            idle = 0;
            if (mode == 1) idle = (i == 2) ? 20 : 1;
            if (mode == 2) idle = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            bus.in_valid = 1'b0;
            for (int j = 0; j < idle; j++) begin
                bus.in_byte = 8'($urandom);
                if (mode == 1 && i == 2 && j == 5) begin
                    bus.start      = 1'b1;
                    bus.base_addr  = 32'hA5A5_A5A0;
                    bus.word_count = 16'd7;
                end else begin
                    bus.start = 1'b0;
                end
                @(posedge clk);
                #1;
            end
            bus.start    = 1'b0;
            bus.in_byte  = tx_bytes[i];
            bus.in_valid = 1'b1;
            ok = 1'b0;
            for (t = 0; t < 200; t++) begin
                @(negedge clk);
                if (bus.in_ready === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                vectors++;
                miscompares++;
                $display("FAIL byte_accept_timeout: got no in_ready, expected handshake for byte %0d", i);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done pulse, expected one");
        end
        @(posedge clk);
        #1;
        chk("idle_cpu_reset", {31'd0, bus.cpu_reset}, 32'd0);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    // reference model: word w lands at the aligned base plus 4*w, bytes little-endian
    task automatic do_load(input logic [31:0] base, input int wc, input int mode);
        logic [31:0] al;
        al = {base[31:2], 2'b00};
        for (int w = 0; w < wc; w++) begin
            wr_t e;
            e.a = al + 32'(4 * w);
            e.d = {tx_bytes[4*w+3], tx_bytes[4*w+2], tx_bytes[4*w+1], tx_bytes[4*w]};
            sb.push_back(e);
        end
        exp_words = wc;
        pulse_start(base, wc);
        send_bytes(mode);
        wait_done();
    endtask

    task automatic random_bytes(input int n);
        tx_bytes.delete();
        for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        cyc            = 0;
        last_wr_cyc    = 0;
        exp_words      = 0;
        exp_start_cyc  = 0;
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.base_addr  = 32'd0;
        bus.word_count = 16'd0;
        bus.in_byte    = 8'd0;
        bus.in_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset_n = 1'b1;

        tx_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_load(32'h0000_0010, 2, 0);
        do_load(32'h0000_0010, 2, 1);

        tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_load(32'h0000_0013, 1, 0);

        random_bytes(8);
        do_load(32'hFFFF_FFFC, 2, 0);

        tx_bytes.delete();
        do_load(32'h0000_0100, 0, 0);

        tx_bytes = '{8'h11, 8'h22, 8'h33};
        sb.delete();
        exp_words = 2;
        pulse_start(32'h0000_0040, 2);
        send_bytes(0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        tx_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        do_load(32'h0000_0040, 1, 0);

        for (int r = 0; r < 8; r++) begin
            int          wc;
            logic [31:0] base;
            wc   = $urandom_range(0, 4);
            base = (r == 0) ? 32'hFFFF_FFF4 + 32'($urandom_range(0, 3)) : 32'($urandom);
            random_bytes(4 * wc);
            do_load(base, wc, 2);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
